// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
//
// Coprocessor-0 register file. It holds BadVAddr, Count, Compare, Status,
// Cause and EPC. It serves MFC0 reads and MTC0 writes from the pipeline,
// takes exception and ERET commits from the exception unit, and runs the
// Count/Compare timer interrupt.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   raddr / rdata      MFC0 register number and read data (combinational;
//                      a write in the same cycle is not forwarded)
//   wen/waddr/wdata    MTC0 write strobe, register number and data
//   hw_int             external interrupt lines, sampled into Cause.IP[15:10]
//   exp_en             exception commit (exp_epc, exp_code, exp_bd,
//                      exp_bad_vaddr, exp_bad_vaddr_wen qualify it)
//   exl_clean          ERET commit, clears Status.EXL
//   epc_address        registered EPC
//   allow_interrupt    Status.IE & ~Status.EXL
//   interrupt_flag     Cause.IP & Status.IM
//   timer_int          Cause.TI
// ---------------------------------------------------------------------------
module cp0_regfile #(
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  hw_int,
    input  logic        exp_en,
    input  logic        exl_clean,
    input  logic [31:0] exp_epc,
    input  logic [4:0]  exp_code,
    input  logic [31:0] exp_bad_vaddr,
    input  logic        exp_bad_vaddr_wen,
    input  logic        exp_bd,
    output logic [31:0] epc_address,
    output logic        allow_interrupt,
    output logic [7:0]  interrupt_flag,
    output logic        timer_int
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // A divider of 1 still gets a 1-bit prescaler that simply stays at 0,
    // so Count advances on every edge.
    localparam int             PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [31:0]   badvaddr_reg;
    logic [31:0]   count_reg;
    logic [31:0]   compare_reg;
    logic [31:0]   epc_reg;
    logic [PW-1:0] presc_reg;
    logic [7:0]    im_reg;
    logic          exl_reg;
    logic          ie_reg;
    logic          bd_reg;
    logic          ti_reg;
    logic [5:0]    hw_ip_reg;
    logic [1:0]    sw_ip_reg;
    logic [4:0]    exc_code_reg;

    logic          wr_count;
    logic          wr_compare;
    logic          wr_status;
    logic          wr_cause;
    logic          wr_epc;
    logic [7:0]    cause_ip;
    logic [31:0]   status_word;
    logic [31:0]   cause_word;

    // BadVAddr is deliberately absent: MTC0 to it is dropped.
    assign wr_count   = wen && (waddr == REG_COUNT);
    assign wr_compare = wen && (waddr == REG_COMPARE);
    assign wr_status  = wen && (waddr == REG_STATUS);
    assign wr_cause   = wen && (waddr == REG_CAUSE);
    assign wr_epc     = wen && (waddr == REG_EPC);

    // The timer shares the top interrupt line with hw_int[5].
    assign cause_ip = {hw_ip_reg[5] | ti_reg, hw_ip_reg[4:0], sw_ip_reg};

    assign status_word = {9'b0, STATUS_RESET[22], 6'b0, im_reg, 6'b0, exl_reg, ie_reg};
    assign cause_word  = {bd_reg, ti_reg, 14'b0, cause_ip, 1'b0, exc_code_reg, 2'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_reg <= '0;
            count_reg    <= '0;
            compare_reg  <= '0;
            epc_reg      <= '0;
            presc_reg    <= '0;
            im_reg       <= STATUS_RESET[15:8];
            exl_reg      <= STATUS_RESET[1];
            ie_reg       <= STATUS_RESET[0];
            bd_reg       <= 1'b0;
            ti_reg       <= 1'b0;
            hw_ip_reg    <= '0;
            sw_ip_reg    <= '0;
            exc_code_reg <= '0;
        end else begin
            hw_ip_reg <= hw_int;

            // A software load restarts the prescaler and replaces the
            // increment that would have happened on this edge.
            if (wr_count) begin
                count_reg <= wdata;
                presc_reg <= '0;
            end else if (presc_reg == PRESC_LAST) begin
                count_reg <= count_reg + 32'd1;
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end

            if (wr_compare) begin
                compare_reg <= wdata;
            end

            // Sticky match flag; rewriting Compare is the acknowledge and
            // beats a match seen on the same edge.
            if (wr_compare) begin
                ti_reg <= 1'b0;
            end else if (count_reg == compare_reg) begin
                ti_reg <= 1'b1;
            end

            if (wr_status) begin
                im_reg <= wdata[15:8];
                ie_reg <= wdata[0];
            end

            if (exp_en) begin
                exl_reg <= 1'b1;
            end else if (exl_clean) begin
                exl_reg <= 1'b0;
            end else if (wr_status) begin
                exl_reg <= wdata[1];
            end

            if (wr_cause) begin
                sw_ip_reg <= wdata[9:8];
            end

            // Nested exceptions (EXL already set) keep the original return
            // address and delay-slot flag.
            if (exp_en) begin
                exc_code_reg <= exp_code;
                if (!exl_reg) begin
                    bd_reg <= exp_bd;
                end
                if (exp_bad_vaddr_wen) begin
                    badvaddr_reg <= exp_bad_vaddr;
                end
            end

            if (exp_en && !exl_reg) begin
                epc_reg <= exp_epc;
            end else if (wr_epc) begin
                epc_reg <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_reg;
            REG_COUNT:    rdata = count_reg;
            REG_COMPARE:  rdata = compare_reg;
            REG_STATUS:   rdata = status_word;
            REG_CAUSE:    rdata = cause_word;
            REG_EPC:      rdata = epc_reg;
            default:      rdata = '0;
        endcase
    end

    assign epc_address     = epc_reg;
    assign allow_interrupt = ie_reg & ~exl_reg;
    assign timer_int       = ti_reg;

    for (genvar gi = 0; gi < 8; gi++) begin : g_int_mask
        assign interrupt_flag[gi] = cause_ip[gi] & im_reg[gi];
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// ---------------------------------------------------------------------------
// tb_cp0_regfile
//
// Directed walk through the CP0 behaviours with literal expectations,
// followed by a long randomized run. A behavioural model (registers held as
// whole 32-bit words, Count derived from cycles elapsed since the last load)
// is compared with the DUT outputs on every falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_cp0_regfile;

    localparam int          COUNT_DIV    = 2;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  hw_int;
    logic        exp_en;
    logic        exl_clean;
    logic [31:0] exp_epc;
    logic [4:0]  exp_code;
    logic [31:0] exp_bad_vaddr;
    logic        exp_bad_vaddr_wen;
    logic        exp_bd;
    logic [31:0] epc_address;
    logic        allow_interrupt;
    logic [7:0]  interrupt_flag;
    logic        timer_int;

    int n_checks = 0;
    int n_errors = 0;

    cp0_regfile #(
        .COUNT_DIV    (COUNT_DIV),
        .STATUS_RESET (STATUS_RESET)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .raddr             (raddr),
        .rdata             (rdata),
        .wen               (wen),
        .waddr             (waddr),
        .wdata             (wdata),
        .hw_int            (hw_int),
        .exp_en            (exp_en),
        .exl_clean         (exl_clean),
        .exp_epc           (exp_epc),
        .exp_code          (exp_code),
        .exp_bad_vaddr     (exp_bad_vaddr),
        .exp_bad_vaddr_wen (exp_bad_vaddr_wen),
        .exp_bd            (exp_bd),
        .epc_address       (epc_address),
        .allow_interrupt   (allow_interrupt),
        .interrupt_flag    (interrupt_flag),
        .timer_int         (timer_int)
    );

    always #10 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit              m_valid = 1'b0;
    logic [31:0]     m_badv, m_load, m_compare, m_status, m_epc;
    longint unsigned m_cyc;
    logic            m_ti, m_bd;
    logic [5:0]      m_hw;
    logic [1:0]      m_swip;
    logic [4:0]      m_code;

    function automatic logic [31:0] m_count();
        return m_load + 32'(m_cyc / COUNT_DIV);
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'b0, m_hw[5] | m_ti, m_hw[4:0], m_swip, 1'b0, m_code, 2'b0};
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        logic        old_exl;
        logic        new_ti;
        if (rst) begin
            m_valid   = 1'b1;
            m_badv    = 0; m_load = 0; m_compare = 0; m_epc = 0;
            m_status  = STATUS_RESET;
            m_cyc     = 0;
            m_ti      = 0; m_bd = 0; m_hw = 0; m_swip = 0; m_code = 0;
        end else if (m_valid) begin
            old_exl = m_status[1];
            new_ti  = m_ti | (m_count() == m_compare);
            m_cyc   = m_cyc + 1;
            m_hw    = hw_int;
            if (wen) begin
                case (waddr)
                    5'd9:  begin m_load = wdata; m_cyc = 0; end
                    5'd11: begin m_compare = wdata; new_ti = 1'b0; end
                    5'd12: m_status = (m_status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
                    5'd13: m_swip = wdata[9:8];
                    5'd14: m_epc = wdata;
                    default: ;
                endcase
            end
            if (exl_clean && !exp_en) m_status[1] = 1'b0;
            if (exp_en) begin
                m_status[1] = 1'b1;
                m_code = exp_code;
                if (!old_exl) begin
                    m_epc = exp_epc;
                    m_bd  = exp_bd;
                end
                if (exp_bad_vaddr_wen) m_badv = exp_bad_vaddr;
            end
            m_ti = new_ti;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: DUT vs model on every falling edge.
    always @(negedge clk) begin
        logic [31:0] c;
        if (m_valid) begin
            c = m_cause();
            chk("model_rdata", rdata, m_rdata(raddr));
            chk("model_epc_address", epc_address, m_epc);
            chk("model_allow_interrupt", {31'b0, allow_interrupt},
                {31'b0, m_status[0] & ~m_status[1]});
            chk("model_interrupt_flag", {24'b0, interrupt_flag},
                {24'b0, c[15:8] & m_status[15:8]});
            chk("model_timer_int", {31'b0, timer_int}, {31'b0, m_ti});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
        $display("MTC0 reg%0d <- %08h", a, d);
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(name, rdata, exp);
        $display("MFC0 reg%0d -> %08h", a, rdata);
    endtask

    task automatic exception(input logic [31:0] epc, input logic [4:0] code, input logic bd,
                             input logic bvw, input logic [31:0] bva);
        exp_en = 1'b1; exp_epc = epc; exp_code = code; exp_bd = bd;
        exp_bad_vaddr_wen = bvw; exp_bad_vaddr = bva;
        tick();
        exp_en = 1'b0; exp_bad_vaddr_wen = 1'b0;
        $display("EXC epc=%08h code=%02h bd=%0d", epc, code, bd);
    endtask

    task automatic eret();
        exl_clean = 1'b1;
        tick();
        exl_clean = 1'b0;
        $display("ERET");
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 7))
            0: return 5'd8;
            1: return 5'd9;
            2: return 5'd11;
            3: return 5'd12;
            4: return 5'd13;
            5: return 5'd14;
            default: return 5'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; raddr = 0; wen = 0; waddr = 0; wdata = 0; hw_int = 0;
        exp_en = 0; exl_clean = 0; exp_epc = 0; exp_code = 0;
        exp_bad_vaddr = 0; exp_bad_vaddr_wen = 0; exp_bd = 0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state (first cycle out of reset, before TI can latch 0==0)
        rd("rst_status", 5'd12, 32'h0040_0000);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_count", 5'd9, 32'h0);
        chk("rst_allow", {31'b0, allow_interrupt}, 32'h0);
        chk("rst_flag", {24'b0, interrupt_flag}, 32'h0);

        // Park Compare far away; the write also acknowledges TI.
        mtc0(5'd11, 32'h7FFF_FFFF);
        chk("ti_cleared", {31'b0, timer_int}, 32'h0);

        // Interrupt masking and 1-cycle hw_int latency
        mtc0(5'd12, 32'h0000_FF01);
        hw_int = 6'b000001;
        chk("hw_int_latency", {24'b0, interrupt_flag}, 32'h0);
        tick();
        chk("irq_flag", {24'b0, interrupt_flag}, 32'h04);
        chk("allow_on", {31'b0, allow_interrupt}, 32'h1);
        hw_int = 6'b0;
        tick();

        // Exception entry, nested exception, ERET
        exception(32'hBFC0_0100, 5'h0C, 1'b1, 1'b0, 32'h0);
        rd("exc_epc", 5'd14, 32'hBFC0_0100);
        chk("exc_epc_address", epc_address, 32'hBFC0_0100);
        rd("exc_cause", 5'd13, 32'h8000_0030);
        chk("exc_allow_off", {31'b0, allow_interrupt}, 32'h0);
        exception(32'h0000_1234, 5'h05, 1'b0, 1'b0, 32'h0);
        rd("nested_epc", 5'd14, 32'hBFC0_0100);
        rd("nested_cause", 5'd13, 32'h8000_0014);
        eret();
        rd("eret_status", 5'd12, 32'h0040_FF01);
        chk("eret_allow", {31'b0, allow_interrupt}, 32'h1);

        // BadVAddr capture and MTC0 immunity
        exception(32'h0000_2000, 5'h04, 1'b0, 1'b1, 32'h8000_0003);
        rd("badvaddr", 5'd8, 32'h8000_0003);
        rd("badv_cause", 5'd13, 32'h0000_0010);
        mtc0(5'd8, 32'h0);
        rd("badvaddr_ro", 5'd8, 32'h8000_0003);
        eret();

        // Count/Compare timer
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd10);
        repeat (19) tick();
        rd("count_10", 5'd9, 32'd10);
        chk("ti_not_yet", {31'b0, timer_int}, 32'h0);
        tick();
        chk("ti_set", {31'b0, timer_int}, 32'h1);
        chk("ti_flag7", {24'b0, interrupt_flag}, 32'h80);
        rd("ti_cause", 5'd13, 32'h4000_8010);
        mtc0(5'd11, 32'd100);
        chk("ti_ack", {31'b0, timer_int}, 32'h0);

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd("count_max", 5'd9, 32'hFFFF_FFFF);
        repeat (COUNT_DIV) tick();
        rd("count_wrap", 5'd9, 32'h0);

        // Exception beats a same-cycle MTC0 Status
        wen = 1'b1; waddr = 5'd12; wdata = 32'h0;
        exception(32'h0000_3000, 5'h08, 1'b0, 1'b0, 32'h0);
        wen = 1'b0;
        rd("exc_vs_mtc0", 5'd12, 32'h0040_0002);
        eret();

        // Reset mid-operation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("RESET");
        rd("rst2_status", 5'd12, 32'h0040_0000);
        rd("rst2_cause", 5'd13, 32'h0);
        rd("rst2_count", 5'd9, 32'h0);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            raddr     = pick_reg();
            wen       = ($urandom_range(0, 2) == 0);
            waddr     = pick_reg();
            wdata     = $urandom;
            if (waddr == 5'd11 && $urandom_range(0, 1) == 1)
                wdata = m_count() + 32'($urandom_range(0, 6));
            if (waddr == 5'd9 && $urandom_range(0, 3) == 0)
                wdata = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            hw_int    = 6'($urandom);
            exp_en    = ($urandom_range(0, 9) == 0);
            exl_clean = !exp_en && ($urandom_range(0, 7) == 0);
            exp_epc   = $urandom;
            exp_code  = 5'($urandom);
            exp_bd    = 1'($urandom);
            exp_bad_vaddr     = $urandom;
            exp_bad_vaddr_wen = 1'($urandom);
            if (exp_en && waddr == 5'd14) wen = 1'b0;
            if (exl_clean && waddr == 5'd12) wen = 1'b0;
            tick();
        end

        rst = 0; wen = 0; exp_en = 0; exl_clean = 0; hw_int = 0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file: consumes the exception unit's outputs (cp0_exp_*, cp0_exl_clean) and feeds it back epc_address, allow_interrupt and interrupt_flag.
- Also serves MFC0 reads and MTC0 writes from the pipeline.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC, and runs the Count/Compare timer interrupt.

Parameters:
- COUNT_DIV, 2, core clock cycles per Count increment (power of two, ≥1).
- STATUS_RESET, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- raddr  in  5  MFC0 register number
- rdata  out  32  MFC0 read data, combinational
- wen  in  1  MTC0 write strobe
- waddr  in  5  MTC0 register number
- wdata  in  32  MTC0 write data
- hw_int  in  6  external interrupt lines, level-sensitive
- exp_en  in  1  exception commit
- exl_clean  in  1  ERET commit
- exp_epc  in  32  faulting PC, already BD-adjusted
- exp_code  in  5  ExcCode
- exp_bad_vaddr  in  32  bad address
- exp_bad_vaddr_wen  in  1  BadVAddr update enable
- exp_bd  in  1  faulting instruction in delay slot
- epc_address  out  32  current EPC
- allow_interrupt  out  1  Status.IE & ~Status.EXL
- interrupt_flag  out  8  Cause.IP[15:8] & Status.IM[15:8]
- timer_int  out  1  Cause.TI

Behaviour:
- Register map, by reg number:
  - 8 BadVAddr: read-only to MTC0.
  - 9 Count.
  - 11 Compare.
  - 12 Status: writable bits IM[15:8], EXL[1], IE[0]; BEV[22] read-only; other bits read 0.
  - 13 Cause: writable bits IP[9:8] only; BD[31], TI[30], IP[15:10], ExcCode[6:2] are hardware-owned.
  - 14 EPC: fully writable.
- Any other raddr reads 0. MTC0 to an unmapped or read-only register is ignored.
- Reset values: Status=STATUS_RESET; all other registers 0; prescaler 0; rdata follows raddr.
- Cause.IP[15:10] are registered from hw_int each cycle, giving 1-cycle latency.
- Cause.IP[15] = hw_int[5] | TI.
- Reads are combinational from current state. A same-cycle MTC0 is not forwarded, so the old value is returned.
- All writes take effect at the clk edge.
- Count:
  - Prescaler counts 0..COUNT_DIV-1; Count increments when the prescaler wraps.
  - Count wraps 32'hFFFF_FFFF→0.
  - MTC0 Count loads wdata, clears the prescaler, and suppresses that cycle's increment.
- TI:
  - Set the cycle after Count==Compare (registered values, Compare≠0 not required).
  - Sticky.
  - Cleared by MTC0 Compare. If set and clear happen in the same cycle, clear wins.
- exp_en=1 (takes priority over MTC0 to the same field in the same cycle):
  - Status.EXL←1.
  - Cause.ExcCode←exp_code.
  - If Status.EXL was 0: EPC←exp_epc and Cause.BD←exp_bd. If EXL was already 1, EPC and BD are unchanged.
  - If exp_bad_vaddr_wen: BadVAddr←exp_bad_vaddr.
- exl_clean=1: Status.EXL←0. exp_en and exl_clean never both assert; if they do, exp_en wins.
- epc_address is the registered EPC. An MTC0 EPC followed by ERET on the next cycle sees the new value.
- Outputs allow_interrupt, interrupt_flag and timer_int are combinational from registers only; there is no combinational path from the exp_* inputs.
- rst mid-operation: all state returns to reset values on the next edge, including the prescaler and TI.

Test Plan:
- Reset → Status reads 0x0040_0000; Cause/EPC/Count read 0; allow_interrupt=0; interrupt_flag=0.
- MTC0 Status←0x0000_FF01, then hw_int=6'b000001 → interrupt_flag=0x04 one cycle later; allow_interrupt=1.
- exp_en with exp_epc=0xBFC0_0100, code 0x0C, bd=1 → EPC=0xBFC0_0100, Cause=0x8000_0030, EXL=1, allow_interrupt=0.
  - Second exp_en with epc 0x1234 → EPC unchanged, ExcCode updated.
  - exl_clean → EXL=0.
- exp_en, code 0x04, bad_vaddr_wen=1, vaddr 0x8000_0003 → BadVAddr=0x8000_0003.
  - MTC0 BadVAddr←0 → BadVAddr still 0x8000_0003.
- MTC0 Compare←10, MTC0 Count←0 → Count reaches 10 after 20 cycles; TI=1 and interrupt_flag[7]=1 (IM7 set).
  - MTC0 Compare←100 → TI=0 next cycle.
- MTC0 Count←0xFFFF_FFFF → wraps to 0 after COUNT_DIV cycles.
  - Simultaneous exp_en and MTC0 Status←0 → EXL=1 (exception wins).
